mem_resp: RTL and testbench
===========================

MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 SHALL have parameter IO_AW, default 16: I/O address width; I/O accesses wrap modulo 2^IO_AW.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  1  CPU access request; held stable with addr/wr_data/we/m_io/byteop until mem_rdy.
REQ-005 SHALL have port addr  input  20  CPU byte address.
REQ-006 SHALL have port wr_data  input  16  write data; low byte at addr, high byte at addr+1.
REQ-007 SHALL have port we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port m_io  input  1  1 = I/O space, 0 = memory space.
REQ-009 SHALL have port byteop  input  1  1 = byte access, 0 = word access.
REQ-010 SHALL have port mem_rdy  output  1  one-cycle access-complete strobe.
REQ-011 SHALL have port memout  output  16  registered read data.
REQ-012 SHALL have ports wb_adr_o  output  19, wb_sel_o  output  2, wb_dat_o  output  16, wb_we_o  output  1, wb_tga_o  output  1 (=m_io), wb_cyc_o  output  1, wb_stb_o  output  1: 16-bit word-addressed bus master outputs.
REQ-013 SHALL have ports wb_dat_i  input  16, wb_ack_i  input  1: bus slave responses.

Function
REQ-014 SHALL implement states IDLE, CYC1, CYC2, DONE.
REQ-015 IDLE: req=1 at a clock edge SHALL latch addr/wr_data/we/m_io/byteop and enter CYC1; req=0 SHALL stay in IDLE.
REQ-016 wb_cyc_o and wb_stb_o SHALL be 1 exactly in CYC1 and CYC2.
REQ-017 CYC1 SHALL drive wb_adr_o=addr[19:1]; wb_sel_o=2'b01 (byte, addr[0]=0), 2'b10 (byte, addr[0]=1), 2'b11 (word, addr[0]=0), 2'b10 (word, addr[0]=1).
REQ-018 Write lane steering: byte lane selected SHALL carry wr_data[7:0]; aligned word drives wr_data unchanged; odd word CYC1 drives wr_data[7:0] on wb_dat_o[15:8].
REQ-019 CYC1 with wb_ack_i=1 SHALL go to CYC2 for odd word access, else to DONE; without ack SHALL hold all bus outputs (unlimited wait states).
REQ-020 CYC2 SHALL drive wb_adr_o=addr[19:1]+1, wb_sel_o=2'b01, wr_data[15:8] on wb_dat_o[7:0]; ack SHALL go to DONE.
REQ-021 Memory CYC2 address SHALL wrap 0x7FFFF->0x00000; I/O address bits at and above IO_AW SHALL be zero in both cycles, wrapping within 2^IO_AW.
REQ-022 Reads: data SHALL be captured on ack; byte read memout={8'h00, selected byte}; aligned word memout=wb_dat_i; odd word memout[7:0]=CYC1 wb_dat_i[15:8], memout[15:8]=CYC2 wb_dat_i[7:0].
REQ-023 memout SHALL be unchanged by writes and SHALL hold until the next read completes.
REQ-024 DONE SHALL assert mem_rdy for exactly one cycle, then return to IDLE unconditionally; req still high in DONE SHALL not start an access.
REQ-025 Zero-wait aligned access latency: req sampled edge N, mem_rdy high in cycle N+2; odd word: N+3.
REQ-026 wb_ack_i in IDLE or DONE SHALL be ignored.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, mem_rdy=0, memout=16'h0000, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0, wb_tga_o=0, including mid-access.
REQ-028 After reset release, first access SHALL start only on a fresh req sample in IDLE.

Structure
REQ-029 State encodings SHALL be constants in the shared defines file.
REQ-030 Byte-lane steering (sel, write data, read merge) SHALL be one combinational sub-module mem_lane.

Verification
REQ-031 Aligned word read, addr=0x12344, ack 0-wait, wb_dat_i=0xBEEF -> one cycle, sel=11, adr=0x091A2, memout=0xBEEF, mem_rdy at N+2.
REQ-032 Odd word write, addr=0x00101, wr_data=0xA55A -> CYC1 adr=0x00080 sel=10 dat[15:8]=0x5A; CYC2 adr=0x00081 sel=01 dat[7:0]=0xA5.
REQ-033 Odd word read at 0xFFFFF, m_io=0 -> CYC2 adr=0x00000; responses 0x11xx then 0xxx22 -> memout=0x2211.
REQ-034 I/O byte read port 0x03DA, ack after 3 wait cycles, wb_dat_i=0x0900 -> tga=1, sel=01, memout=0x0000... then port 0x03DB -> sel=10, memout=0x0009.
REQ-035 rst=0 during CYC1 wait -> cyc/stb drop same cycle, no mem_rdy; next req runs a full fresh access.
REQ-036 req held high through DONE -> exactly one access, mem_rdy single pulse; second access starts only after IDLE.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// mem_resp shared definitions: FSM state encodings,
// bus widths and the I/O word-address mask helper.
package mem_resp_pkg;

  localparam int unsigned MEM_AW = 20;
  localparam int unsigned WB_AW  = 19;
  localparam int unsigned DW     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CYC1 = 2'd1,
    ST_CYC2 = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Word-address mask keeping an I/O access inside 2^io_aw bytes.
  function automatic logic [WB_AW-1:0] io_wmask(
    input int unsigned io_aw
  );
    return {WB_AW{1'b1}} >> (MEM_AW - io_aw);
  endfunction

endpackage

// File: rtl/mem_lane.sv
// mem_lane: byte-lane steering for one bus phase.
// Picks lane selects, write-data placement and read-data merge.
module mem_lane
  import mem_resp_pkg::*;
(
  input  logic          i_cyc2,
  input  logic          i_byteop,
  input  logic          i_a0,
  input  logic [DW-1:0] i_wdata,
  input  logic [DW-1:0] i_rdata,
  input  logic [7:0]    i_lo_hold,
  output logic [1:0]    o_sel,
  output logic [DW-1:0] o_wdata,
  output logic [DW-1:0] o_rdata
);

  // Lane decode; the default arm is the first phase of an odd word.
  always_comb begin
    o_sel   = 2'b00;
    o_wdata = '0;
    o_rdata = '0;
    unique case (1'b1)
      i_cyc2: begin
        o_sel   = 2'b01;
        o_wdata = {8'h00, i_wdata[15:8]};
        o_rdata = {i_rdata[7:0], i_lo_hold};
      end
      (!i_cyc2 && i_byteop && !i_a0): begin
        o_sel   = 2'b01;
        o_wdata = {8'h00, i_wdata[7:0]};
        o_rdata = {8'h00, i_rdata[7:0]};
      end
      (!i_cyc2 && i_byteop && i_a0): begin
        o_sel   = 2'b10;
        o_wdata = {i_wdata[7:0], 8'h00};
        o_rdata = {8'h00, i_rdata[15:8]};
      end
      (!i_cyc2 && !i_byteop && !i_a0): begin
        o_sel   = 2'b11;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
      default: begin
        o_sel   = 2'b10;
        o_wdata = {i_wdata[7:0], 8'h00};
        o_rdata = {8'h00, i_rdata[15:8]};
      end
    endcase
  end

endmodule

// File: rtl/mem_resp.sv
// mem_resp: CPU byte/word access to a 16-bit word bus.
// Odd words split into two bus cycles; reads are registered.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int unsigned IO_AW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [19:0]      addr,
  input  logic [15:0]      wr_data,
  input  logic             we,
  input  logic             m_io,
  input  logic             byteop,
  output logic             mem_rdy,
  output logic [15:0]      memout,
  output logic [18:0]      wb_adr_o,
  output logic [1:0]       wb_sel_o,
  output logic [15:0]      wb_dat_o,
  output logic             wb_we_o,
  output logic             wb_tga_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  input  logic [15:0]      wb_dat_i,
  input  logic             wb_ack_i
);

  localparam logic [WB_AW-1:0] IO_WMASK = io_wmask(IO_AW);

  state_e            r_state;
  state_e            w_next;
  logic [19:0]       r_addr;
  logic [15:0]       r_wdata;
  logic              r_we;
  logic              r_io;
  logic              r_byte;
  logic [15:0]       r_memout;
  logic [7:0]        r_lo;

  logic              w_odd;
  logic              w_cyc2;
  logic              w_bus;
  logic [WB_AW-1:0]  w_adr_raw;
  logic [WB_AW-1:0]  w_adr;
  logic [1:0]        w_sel;
  logic [15:0]       w_wdata;
  logic [15:0]       w_rdata;

  assign w_odd  = !r_byte && r_addr[0];
  assign w_cyc2 = (r_state == ST_CYC2);
  assign w_bus  = (r_state == ST_CYC1) || w_cyc2;

  assign w_adr_raw = w_cyc2 ? (r_addr[19:1] + 19'd1)
                            : r_addr[19:1];
  assign w_adr     = r_io ? (w_adr_raw & IO_WMASK)
                          : w_adr_raw;

  mem_lane u_lane (
    .i_cyc2    (w_cyc2),
    .i_byteop  (r_byte),
    .i_a0      (r_addr[0]),
    .i_wdata   (r_wdata),
    .i_rdata   (wb_dat_i),
    .i_lo_hold (r_lo),
    .o_sel     (w_sel),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state: wait states hold CYC1/CYC2 until ack.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (req) w_next = ST_CYC1;
      ST_CYC1: if (wb_ack_i) w_next = w_odd ? ST_CYC2 : ST_DONE;
      ST_CYC2: if (wb_ack_i) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Bus outputs live only in CYC1/CYC2; everything else is zero.
  always_comb begin
    mem_rdy  = (r_state == ST_DONE);
    wb_cyc_o = w_bus;
    wb_stb_o = w_bus;
    wb_adr_o = '0;
    wb_sel_o = '0;
    wb_dat_o = '0;
    wb_we_o  = 1'b0;
    wb_tga_o = 1'b0;
    if (w_bus) begin
      wb_adr_o = w_adr;
      wb_sel_o = w_sel;
      wb_dat_o = w_wdata;
      wb_we_o  = r_we;
      wb_tga_o = r_io;
    end
  end

  // Request capture at the start of an access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_io    <= 1'b0;
      r_byte  <= 1'b0;
    end else if (r_state == ST_IDLE && req) begin
      r_addr  <= addr;
      r_wdata <= wr_data;
      r_we    <= we;
      r_io    <= m_io;
      r_byte  <= byteop;
    end
  end

  // Read capture; odd words park the low byte until CYC2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_memout <= '0;
      r_lo     <= '0;
    end else if (wb_ack_i && !r_we) begin
      if (r_state == ST_CYC1) begin
        if (w_odd) r_lo     <= w_rdata[7:0];
        else       r_memout <= w_rdata;
      end else if (w_cyc2) begin
        r_memout <= w_rdata;
      end
    end
  end

  assign memout = r_memout;

endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: directed scoreboard bench for mem_resp.
// Bus phases and responses are queued at issue, popped by a monitor.
module tb_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [19:0] addr = '0;
  logic [15:0] wr_data = '0;
  logic        we = 1'b0;
  logic        m_io = 1'b0;
  logic        byteop = 1'b0;
  logic        mem_rdy;
  logic [15:0] memout;
  logic [18:0] wb_adr_o;
  logic [1:0]  wb_sel_o;
  logic [15:0] wb_dat_o;
  logic        wb_we_o, wb_tga_o, wb_cyc_o, wb_stb_o;
  logic [15:0] wb_dat_i = '0;
  logic        wb_ack_i;
  logic        slv_ack = 1'b0;
  logic        stray_ack = 1'b0;

  assign wb_ack_i = slv_ack | stray_ack;

  mem_resp #(.IO_AW(16)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr),
    .wr_data(wr_data), .we(we), .m_io(m_io),
    .byteop(byteop), .mem_rdy(mem_rdy), .memout(memout),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o),
    .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_tga_o(wb_tga_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] adr;
    logic [1:0]  sel;
    logic [15:0] dat;
    logic [15:0] msk;
    logic        we;
    logic        tga;
  } bus_t;

  typedef struct {
    logic [15:0] memout;
    int          cyc;
  } rsp_t;

  bus_t        bus_q[$];
  rsp_t        rsp_q[$];
  logic [15:0] slv_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n = 0;
  int slv_waits = 0;
  int slv_cnt = 0;
  logic prev_rdy = 1'b0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Slave model: acks after slv_waits cycles, data from slv_q.
  always @(posedge clk) begin
    #1;
    if (wb_cyc_o && wb_stb_o) begin
      if (slv_cnt >= slv_waits) begin
        slv_ack = 1'b1;
        wb_dat_i = (slv_q.size() > 0) ? slv_q.pop_front() : 16'h0;
        slv_cnt = 0;
      end else begin
        slv_ack = 1'b0;
        slv_cnt++;
      end
    end else begin
      slv_ack = 1'b0;
      slv_cnt = 0;
    end
  end

  // Monitor: checks each acked bus phase and each mem_rdy pulse.
  always @(negedge clk) begin
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      n_checks++;
      if (bus_q.size() == 0) begin
        n_errors++;
        $display("FAIL bus_phase: unexpected phase adr=%h", wb_adr_o);
      end else begin
        bus_t e;
        e = bus_q.pop_front();
        if (wb_adr_o !== e.adr || wb_sel_o !== e.sel ||
            wb_we_o !== e.we || wb_tga_o !== e.tga ||
            ((wb_dat_o ^ e.dat) & e.msk) != 16'h0) begin
          n_errors++;
          $display("FAIL bus_phase: got adr=%h sel=%b dat=%h we=%b tga=%b, expected adr=%h sel=%b dat=%h/%h we=%b tga=%b",
                   wb_adr_o, wb_sel_o, wb_dat_o, wb_we_o, wb_tga_o,
                   e.adr, e.sel, e.dat, e.msk, e.we, e.tga);
        end
      end
    end
    if (mem_rdy) begin
      n_checks++;
      if (prev_rdy) begin
        n_errors++;
        $display("FAIL rdy_pulse: mem_rdy high 2 cycles, expected 1");
      end else if (rsp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rdy_pulse: unexpected mem_rdy, expected none");
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        if (memout !== r.memout ||
            (r.cyc >= 0 && cyc_n != r.cyc)) begin
          n_errors++;
          $display("FAIL response: got memout=%h cyc=%0d, expected memout=%h cyc=%0d",
                   memout, cyc_n, r.memout, r.cyc);
        end
      end
    end
    prev_rdy = mem_rdy;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pb(input logic [18:0] adr, input logic [1:0] sel,
                    input logic [15:0] dat, input logic [15:0] msk,
                    input logic w, input logic io);
    bus_t e;
    e.adr = adr; e.sel = sel; e.dat = dat;
    e.msk = msk; e.we = w; e.tga = io;
    bus_q.push_back(e);
  endtask

  // Issue one access; lat<0 means latency is not checked.
  task automatic access(input logic [19:0] a, input logic [15:0] wd,
                        input logic w, input logic io,
                        input logic bo, input int waits,
                        input logic [15:0] exp_mo, input int lat,
                        input bit hold);
    rsp_t r;
    bit got;
    @(negedge clk);
    r.memout = exp_mo;
    r.cyc = (lat < 0) ? -1 : cyc_n + lat;
    rsp_q.push_back(r);
    addr = a; wr_data = wd; we = w; m_io = io; byteop = bo;
    slv_waits = waits;
    req = 1'b1;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (mem_rdy) got = 1;
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: no mem_rdy for addr %h, expected one", a);
    end
    if (hold) @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_memout", 32'(memout), 32'h0);
    chk("rst_rdy", 32'(mem_rdy), 32'h0);
    chk("rst_cyc_stb", {wb_cyc_o, wb_stb_o, wb_we_o, wb_tga_o}, 32'h0);
    chk("rst_adr_sel", {wb_adr_o, wb_sel_o}, 32'h0);
    chk("rst_dat", 32'(wb_dat_o), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // aligned word read, zero wait
    pb(19'h091A2, 2'b11, 16'h0, 16'h0, 1'b0, 1'b0);
    slv_q.push_back(16'hBEEF);
    access(20'h12344, 16'h0, 0, 0, 0, 0, 16'hBEEF, 2, 0);

    // odd word write
    pb(19'h00080, 2'b10, 16'h5A00, 16'hFF00, 1'b1, 1'b0);
    pb(19'h00081, 2'b01, 16'h00A5, 16'h00FF, 1'b1, 1'b0);
    slv_q.push_back(16'h0); slv_q.push_back(16'h0);
    access(20'h00101, 16'hA55A, 1, 0, 0, 0, 16'hBEEF, 3, 0);

    // odd word read at top of memory wraps
    pb(19'h7FFFF, 2'b10, 16'h0, 16'h0, 1'b0, 1'b0);
    pb(19'h00000, 2'b01, 16'h0, 16'h0, 1'b0, 1'b0);
    slv_q.push_back(16'h1134); slv_q.push_back(16'h5522);
    access(20'hFFFFF, 16'h0, 0, 0, 0, 0, 16'h2211, 3, 0);

    // I/O byte reads with 3 wait states
    pb(19'h001ED, 2'b01, 16'h0, 16'h0, 1'b0, 1'b1);
    slv_q.push_back(16'h0900);
    access(20'h003DA, 16'h0, 0, 1, 1, 3, 16'h0000, -1, 0);
    pb(19'h001ED, 2'b10, 16'h0, 16'h0, 1'b0, 1'b1);
    slv_q.push_back(16'h0900);
    access(20'h003DB, 16'h0, 0, 1, 1, 3, 16'h0009, -1, 0);

    // byte and aligned word writes leave memout alone
    pb(19'h00008, 2'b01, 16'h00CD, 16'h00FF, 1'b1, 1'b0);
    slv_q.push_back(16'hFFFF);
    access(20'h00010, 16'h12CD, 1, 0, 1, 0, 16'h0009, 2, 0);
    pb(19'h00008, 2'b10, 16'hCD00, 16'hFF00, 1'b1, 1'b0);
    slv_q.push_back(16'hFFFF);
    access(20'h00011, 16'h12CD, 1, 0, 1, 1, 16'h0009, -1, 0);
    pb(19'h10000, 2'b11, 16'h1234, 16'hFFFF, 1'b1, 1'b0);
    slv_q.push_back(16'hFFFF);
    access(20'h20000, 16'h1234, 1, 0, 0, 0, 16'h0009, 2, 0);

    // I/O odd word wraps within 64 KiB
    pb(19'h07FFF, 2'b10, 16'h0, 16'h0, 1'b0, 1'b1);
    pb(19'h00000, 2'b01, 16'h0, 16'h0, 1'b0, 1'b1);
    slv_q.push_back(16'hAB00); slv_q.push_back(16'h00CD);
    access(20'hFFFFF, 16'h0, 0, 1, 0, 0, 16'hCDAB, 3, 0);

    // I/O aligned word drops high address bits
    pb(19'h0091A, 2'b11, 16'h0, 16'h0, 1'b0, 1'b1);
    slv_q.push_back(16'h7777);
    access(20'h51234, 16'h0, 0, 1, 0, 0, 16'h7777, 2, 0);

    // reset during a CYC1 wait
    @(negedge clk);
    addr = 20'h00400; we = 0; m_io = 0; byteop = 0;
    slv_waits = 1000;
    req = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_cyc_up", 32'(wb_cyc_o), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_cyc", {wb_cyc_o, wb_stb_o}, 32'h0);
    chk("mid_rst_memout", 32'(memout), 32'h0);
    chk("mid_rst_rdy_adr", {mem_rdy, wb_adr_o}, 32'h0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {mem_rdy, wb_cyc_o}, 32'h0);
    pb(19'h00001, 2'b11, 16'h0, 16'h0, 1'b0, 1'b0);
    slv_q.push_back(16'h4321);
    access(20'h00002, 16'h0, 0, 0, 0, 0, 16'h4321, 2, 0);

    // req held through DONE yields one access
    pb(19'h00001, 2'b10, 16'h0, 16'h0, 1'b0, 1'b0);
    slv_q.push_back(16'h5600);
    access(20'h00003, 16'h0, 0, 0, 1, 0, 16'h0056, 2, 1);
    repeat (3) @(negedge clk);
    chk("hold_no_second", {mem_rdy, wb_cyc_o}, 32'h0);

    // ack while idle is ignored
    @(negedge clk);
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_ack_idle", {mem_rdy, wb_cyc_o}, 32'h0);
    chk("stray_memout", 32'(memout), 32'h0056);
    stray_ack = 1'b0;

    repeat (4) @(negedge clk);
    chk("bus_q_empty", 32'(bus_q.size()), 32'h0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
